lcd_num_formatter: RTL and testbench
====================================

// Module: lcd_num_formatter
// PURPOSE
//  Upstream feeder for the 8-character LCD driver. Converts a binary value to decimal
//  with an iterative shift-add-3 (double-dabble) converter. Adds sign, optional decimal
//  point, leading-zero blanking and a unit suffix. Packs the result into the 40-bit
//  character-code bus (8 x 5-bit codes) that the driver scans continuously.
//  The bus only ever changes atomically, so the LCD never shows a half-built number.
// PARAMETERS
//  WIDTH   16  width of value; legal range 2..16
//  SIGNED  1   1: value is two's complement; 0: value is unsigned
// PORTS
//  clk     in   1   system clock
//  rst     in   1   synchronous, active-high reset
//  start   in   1   request a conversion; sampled only while busy=0
//  value   in   WIDTH  number to display
//  dp_pos  in   3   digits after the decimal point: 0 = no point, 1..4 = point position, 5..7 = treated as 0
//  unit    in   5   suffix character code for slot 0 (31 = blank)
//  chars   out  40  character codes; slot n = chars[5n+4:5n]; slot 7 = leftmost on the LCD, slot 0 = rightmost
//  busy    out  1   conversion in progress
//  done    out  1   one-cycle pulse; chars updated on the same edge
// BEHAVIOUR
//  Reset:
//   - chars = 40'hFF_FFFF_FFFF (all blank, code 31); busy = 0; done = 0; state = IDLE.
//   - rst mid-conversion aborts it; no done pulse follows.
//  IDLE:
//   - start=1 at edge E0 -> capture dp_pos, unit and sign.
//   - Capture magnitude mag = |value|, zero-extended to 16 bits. -2^(WIDTH-1) must give the correct positive magnitude.
//   - busy <= 1; cnt <= 0; state <= CONV.
//  CONV:
//   - Each cycle, add 3 to every BCD nibble >= 5, then shift {bcd[19:0], mag} left by 1.
//   - Runs exactly 16 cycles (E1..E16), regardless of WIDTH; then state <= FMT.
//  FMT (E17):
//   - chars <= formatted result; done <= 1 for exactly one cycle; busy <= 0; state <= IDLE.
//   - Latency: done is high in the cycle after E17, i.e. 17 clocks after start was sampled.
//   - A new start is accepted from the cycle in which done is high.
//  start while busy: ignored, not queued. chars holds the previous result until FMT.
//  Format (digits d4..d0, d4 = most significant):
//   - Slot 7: '-' (19) if SIGNED and value < 0, else blank. -0 cannot occur.
//   - dp = 0:
//     - Slot 6 = blank.
//     - Slots 5..1 = d4..d0.
//   - dp = k (1..4):
//     - Slots k..1 = d(k-1)..d0.
//     - Slot k+1 = '.' (16).
//     - Slots 6..k+2 = d4..dk, with d4 in slot 6.
//   - Leading-zero blanking:
//     - Scan digits from d4 downward; each leading 0 becomes blank (31).
//     - Stop at the first nonzero digit.
//     - Never blank the units digit (d0 when dp=0, dk when dp=k) or any digit right of the point.
//   - Slot 0 = unit.
//  Digit codes 0..9 = 5'd0..5'd9.
// STRUCTURE
//  - Shared package: character codes CH_DOT=16, CH_MINUS=19, CH_M=26, CH_S=27, CH_MICRO=28, CH_OHM=29, CH_EQ=30, CH_BLANK=31.
//  - The same package is used by the LCD driver and other feeders.
//  - Sub-module lcd_bin2bcd: 16-bit sequential double-dabble with start/busy/done; 5x4-bit BCD out.
//  - Top level = control FSM (IDLE/CONV/FMT), sign and magnitude capture, combinational slot formatter, chars register.
// TESTING
//  Expected chars given as slots 7..0.
//  1. rst, then value=0, dp=0, unit=31 -> [31,31,31,31,31,31,0,31]; done 17 clocks after start.
//  2. value=-1234, dp=2, unit=26 -> [19,31,1,2,16,3,4,26] ("- 12.34m").
//  3. value=16'h8000, SIGNED=1, dp=0, unit=27 -> [19,31,3,2,7,6,8,27].
//     Same input with SIGNED=0 -> slot 7 = 31, rest unchanged.
//  4. value=5, dp=4, unit=29 -> [31,0,16,0,0,0,5,29] (units digit kept as 0).
//  5. start again 5 cycles after the first start with value=99:
//     - ignored; exactly one done pulse;
//     - chars = first value's result;
//     - a start on the done cycle converts 99.
//  6. rst at CONV cycle 8:
//     - chars all 31, busy=0, no done pulse;
//     - next start gives the correct result 17 clocks later.
//  Checks at every clock:
//   - chars changes only on the edge where done rises;
//   - busy and done are never both high.

Source files
------------

// File: rtl/lcd_num_formatter_pkg.sv
// Shared LCD character codes, converter sizing and the formatter FSM state type.
// The LCD driver and the other display feeders import this package too.
package lcd_num_formatter_pkg;

    localparam logic [4:0] CH_DOT   = 5'd16;
    localparam logic [4:0] CH_MINUS = 5'd19;
    localparam logic [4:0] CH_M     = 5'd26;
    localparam logic [4:0] CH_S     = 5'd27;
    localparam logic [4:0] CH_MICRO = 5'd28;
    localparam logic [4:0] CH_OHM   = 5'd29;
    localparam logic [4:0] CH_EQ    = 5'd30;
    localparam logic [4:0] CH_BLANK = 5'd31;

    localparam int BIN_BITS   = 16;
    localparam int BCD_DIGITS = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_FMT
    } fmt_state_t;

    // One double-dabble iteration on {bcd[19:0], bin[15:0]}: every BCD nibble
    // of 5 or more gets +3, then the whole vector shifts left by one.
    function automatic logic [35:0] dd_step(input logic [35:0] x);
        logic [35:0] y;
        y = x;
        for (int n = 0; n < BCD_DIGITS; n++) begin
            if (y[BIN_BITS + 4*n +: 4] >= 4'd5) begin
                y[BIN_BITS + 4*n +: 4] = y[BIN_BITS + 4*n +: 4] + 4'd3;
            end
        end
        return {y[34:0], 1'b0};
    endfunction

endpackage

// File: rtl/lcd_bin2bcd.sv
// Sequential 16-bit binary to 5-digit BCD converter (shift-add-3).
// The first of the 16 iterations is folded into the load, because the BCD
// part is still zero then and no nibble can need a correction. That way the
// done pulse lines up one cycle earlier for the control FSM above.
module lcd_bin2bcd
    import lcd_num_formatter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd
);

    logic [35:0] sr;
    logic [3:0]  cnt;

    // Load plus first shift on start, then fifteen more iterations; done pulses after the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr   <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                sr   <= dd_step({20'd0, bin});
                cnt  <= 4'd1;
                busy <= 1'b1;
            end else if (busy) begin
                sr  <= dd_step(sr);
                cnt <= cnt + 4'd1;
                if (cnt == 4'd15) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign bcd = sr[35:16];

endmodule

// File: rtl/lcd_num_formatter.sv
// Number formatter feeding the 8-character LCD driver: sign/magnitude capture,
// BCD conversion, decimal point, leading-zero blanking and unit suffix.
// chars is only ever written as a whole, on the edge that raises done.
module lcd_num_formatter
    import lcd_num_formatter_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    input  logic [2:0]       dp_pos,
    input  logic [4:0]       unit,
    output logic [39:0]      chars,
    output logic             busy,
    output logic             done
);

    fmt_state_t  state, next_state;
    logic        capture, fmt_load;
    logic [15:0] val16, mag16;
    logic        neg_in;
    logic        neg_q;
    logic [2:0]  dp_q;
    logic [4:0]  unit_q;
    logic        bcd_busy, bcd_done;
    logic [19:0] bcd;
    logic [4:0]  code [BCD_DIGITS];
    logic        lead;
    logic [29:0] mid;
    logic [39:0] fmt_chars;

    // Widen to 16 bits first and negate there, so the most negative input still gets its full positive magnitude.
    always_comb begin
        if (SIGNED) begin
            val16  = 16'($signed(value));
            neg_in = value[WIDTH-1];
        end else begin
            val16  = 16'(value);
            neg_in = 1'b0;
        end
        mag16 = neg_in ? (16'd0 - val16) : val16;
    end

    lcd_bin2bcd u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (capture),
        .bin   (mag16),
        .busy  (bcd_busy),
        .done  (bcd_done),
        .bcd   (bcd)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: wait for start, follow the converter, then one formatting cycle.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (capture)  next_state = ST_CONV;
            ST_CONV: if (bcd_done) next_state = ST_FMT;
            ST_FMT:                next_state = ST_IDLE;
            default:               next_state = ST_IDLE;
        endcase
    end

    // FSM outputs: busy for the whole conversion, start only accepted when idle.
    always_comb begin
        busy     = (state != ST_IDLE);
        capture  = (state == ST_IDLE) && start && !bcd_busy;
        fmt_load = (state == ST_FMT);
    end

    // Capture sign, point position (out-of-range means no point) and unit with the start request.
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q  <= 1'b0;
            dp_q   <= 3'd0;
            unit_q <= CH_BLANK;
        end else if (capture) begin
            neg_q  <= neg_in;
            dp_q   <= (dp_pos > 3'd4) ? 3'd0 : dp_pos;
            unit_q <= unit;
        end
    end

    // Slot formatter: blank leading zeros down to the units digit, then place digits around the point.
    always_comb begin
        lead = 1'b1;
        for (int i = BCD_DIGITS - 1; i >= 0; i--) begin
            if (lead && (3'(i) > dp_q) && (bcd[4*i +: 4] == 4'd0)) begin
                code[i] = CH_BLANK;
            end else begin
                code[i] = {1'b0, bcd[4*i +: 4]};
                lead    = 1'b0;
            end
        end
        case (dp_q)
            3'd1:    mid = {code[4], code[3], code[2], code[1], CH_DOT,  code[0]};
            3'd2:    mid = {code[4], code[3], code[2], CH_DOT,  code[1], code[0]};
            3'd3:    mid = {code[4], code[3], CH_DOT,  code[2], code[1], code[0]};
            3'd4:    mid = {code[4], CH_DOT,  code[3], code[2], code[1], code[0]};
            default: mid = {CH_BLANK, code[4], code[3], code[2], code[1], code[0]};
        endcase
        fmt_chars = {(neg_q ? CH_MINUS : CH_BLANK), mid, unit_q};
    end

    // Result register: the whole bus and the done pulse update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            chars <= {8{CH_BLANK}};
            done  <= 1'b0;
        end else begin
            done <= fmt_load;
            if (fmt_load) begin
                chars <= fmt_chars;
            end
        end
    end

endmodule

// File: tb/tb_lcd_num_formatter.sv
// Testbench for lcd_num_formatter: scoreboard of expected results built from
// an independent decimal model, checked whenever a done pulse appears.
// A signed and an unsigned instance share the same stimulus.
module tb_lcd_num_formatter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] value = '0;
    logic [2:0]  dp_pos = '0;
    logic [4:0]  unit = 5'd31;
    logic [39:0] chars, chars_u;
    logic        busy, done, busy_u, done_u;

    int          checks = 0;
    int          failures = 0;
    int          cycle = 0;
    logic        rst_q = 1'b1;
    bit          armed = 1'b0;
    logic [39:0] prev_chars = '0;

    typedef struct {
        logic [39:0] chars;
        int          start_cycle;
    } exp_t;

    exp_t        sb[$];
    logic [39:0] sb_u[$];
    exp_t        mon_e;

    lcd_num_formatter #(.WIDTH(16), .SIGNED(1'b1)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .value  (value),
        .dp_pos (dp_pos),
        .unit   (unit),
        .chars  (chars),
        .busy   (busy),
        .done   (done)
    );

    lcd_num_formatter #(.WIDTH(16), .SIGNED(1'b0)) dut_u (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .value  (value),
        .dp_pos (dp_pos),
        .unit   (unit),
        .chars  (chars_u),
        .busy   (busy_u),
        .done   (done_u)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter for latency measurement, and reset as seen by the DUT.
    always @(posedge clk) begin
        cycle <= cycle + 1;
        rst_q <= rst;
    end

    task automatic checkOutput(input string tag, input logic [39:0] obs, input logic [39:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Decimal reference: digits by repeated division, slots filled left to right from the rightmost digit.
    function automatic logic [39:0] modelChars(input logic [15:0] v, input bit sgn,
                                               input logic [2:0] dp, input logic [4:0] u);
        int         m, k, pos;
        bit         neg;
        int         dig [5];
        int         slot_of [5];
        logic [4:0] s [8];
        neg = sgn && v[15];
        m = neg ? (65536 - int'(v)) : int'(v);
        for (int i = 0; i < 5; i++) begin
            dig[i] = m % 10;
            m = m / 10;
        end
        k = (dp > 3'd4) ? 0 : int'(dp);
        for (int i = 0; i < 8; i++) s[i] = 5'd31;
        s[7] = neg ? 5'd19 : 5'd31;
        s[0] = u;
        pos = 1;
        for (int i = 0; i < 5; i++) begin
            if (k != 0 && i == k) begin
                s[pos] = 5'd16;
                pos++;
            end
            slot_of[i] = pos;
            s[pos] = 5'(dig[i]);
            pos++;
        end
        for (int i = 4; i > k; i--) begin
            if (dig[i] != 0) break;
            s[slot_of[i]] = 5'd31;
        end
        return {s[7], s[6], s[5], s[4], s[3], s[2], s[1], s[0]};
    endfunction

    // Drive one start request and record what both instances must produce.
    task automatic applyStimulus(input logic [15:0] v, input logic [2:0] dp, input logic [4:0] u);
        exp_t e;
        value  = v;
        dp_pos = dp;
        unit   = u;
        start  = 1'b1;
        @(posedge clk);
        #1;
        e.chars       = modelChars(v, 1'b1, dp, u);
        e.start_cycle = cycle;
        sb.push_back(e);
        sb_u.push_back(modelChars(v, 1'b0, dp, u));
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) checkOutput(tag, 40'd0, 40'd1);
    endtask

    // Per-cycle monitor: exclusivity, atomic bus updates and scoreboard comparison on done.
    always @(negedge clk) begin
        if (armed) begin
            checkOutput("busy_done_excl", {39'd0, busy & done}, 40'd0);
            if (chars !== prev_chars && !rst_q) begin
                checkOutput("chars_change_on_done", {39'd0, done}, 40'd1);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 40'd1, 40'd0);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("chars", chars, mon_e.chars);
                    checkOutput("latency", 40'(cycle - mon_e.start_cycle), 40'd17);
                end
            end
            if (done_u) begin
                if (sb_u.size() == 0) begin
                    checkOutput("unexpected_done_u", 40'd1, 40'd0);
                end else begin
                    checkOutput("chars_u", chars_u, sb_u.pop_front());
                end
            end
        end
        prev_chars = chars;
    end

    // Main sequence: reset, specified vectors, overlap/abort cases, random values.
    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        armed = 1'b1;
        checkOutput("reset_chars", chars, {8{5'd31}});
        checkOutput("reset_busy", {39'd0, busy}, 40'd0);
        checkOutput("reset_done", {39'd0, done}, 40'd0);

        applyStimulus(16'd0, 3'd0, 5'd31);
        waitDone("t1_timeout");
        checkOutput("t1_chars", chars, {5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd0, 5'd31});

        applyStimulus(16'hFB2E, 3'd2, 5'd26);
        waitDone("t2_timeout");
        checkOutput("t2_chars", chars, {5'd19, 5'd31, 5'd1, 5'd2, 5'd16, 5'd3, 5'd4, 5'd26});

        applyStimulus(16'h8000, 3'd0, 5'd27);
        waitDone("t3_timeout");
        checkOutput("t3_chars", chars, {5'd19, 5'd31, 5'd3, 5'd2, 5'd7, 5'd6, 5'd8, 5'd27});
        checkOutput("t3_chars_u", chars_u, {5'd31, 5'd31, 5'd3, 5'd2, 5'd7, 5'd6, 5'd8, 5'd27});

        applyStimulus(16'd5, 3'd4, 5'd29);
        waitDone("t4_timeout");
        checkOutput("t4_chars", chars, {5'd31, 5'd0, 5'd16, 5'd0, 5'd0, 5'd0, 5'd5, 5'd29});

        applyStimulus(16'd1234, 3'd6, 5'd28);
        waitDone("dp6_timeout");
        checkOutput("dp6_chars", chars, {5'd31, 5'd31, 5'd31, 5'd1, 5'd2, 5'd3, 5'd4, 5'd28});

        applyStimulus(16'd4321, 3'd1, 5'd30);
        repeat (5) @(negedge clk);
        value  = 16'd99;
        dp_pos = 3'd0;
        unit   = 5'd31;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone("t5_timeout");
        checkOutput("t5_chars", chars, {5'd31, 5'd31, 5'd4, 5'd3, 5'd2, 5'd16, 5'd1, 5'd30});
        applyStimulus(16'd99, 3'd0, 5'd31);
        waitDone("t5b_timeout");
        checkOutput("t5b_chars", chars, {5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd9, 5'd9, 5'd31});

        applyStimulus(16'd777, 3'd3, 5'd26);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        sb_u.delete();
        checkOutput("t6_chars", chars, {8{5'd31}});
        checkOutput("t6_busy", {39'd0, busy}, 40'd0);
        repeat (25) @(negedge clk);
        applyStimulus(16'hFFF6, 3'd1, 5'd29);
        waitDone("t6b_timeout");
        checkOutput("t6b_chars", chars, {5'd19, 5'd31, 5'd31, 5'd31, 5'd1, 5'd16, 5'd0, 5'd29});

        for (int r = 0; r < 20; r++) begin
            applyStimulus(16'($urandom), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
            waitDone("rand_timeout");
        end

        repeat (3) @(negedge clk);
        checkOutput("sb_empty", 40'(sb.size()), 40'd0);
        checkOutput("sb_u_empty", 40'(sb_u.size()), 40'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
